hazard_stall_ctrl: RTL and testbench

//  Pipeline sequencer for the 5-stage core. Generates keep (hold) and nop (bubble)
//  for IF/ID/EX/WB stage registers: load-use interlock, taken-branch flush,

---
 rtl/hazard_stall_ctrl.sv | 153 +++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencer for the 5-stage core: load-use interlock, taken-branch flush,
// data-memory wait stall with timeout, plus saturating stall/flush counters.
module hazard_stall_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_use_rs1,
  input  logic             i_id_use_rs2,
  input  logic [4:0]       i_ex_wreg,
  input  logic             i_ex_regwrite,
  input  logic             i_ex_is_load,
  input  logic             i_br_taken,
  input  logic             i_mem_req,
  input  logic             i_mem_ready,
  output logic             o_if_keep,
  output logic             o_id_keep,
  output logic             o_ex_keep,
  output logic             o_id_nop,
  output logic             o_ex_nop,
  output logic             o_wb_nop,
  output logic             o_pc_sel_br,
  output logic             o_err,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_ERR      = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(MEM_TIMEOUT);
  localparam bit               TO_EN   = (MEM_TIMEOUT != 0);

  state_t           r_state;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_mem_stall;
  logic w_lu_hz;
  logic w_timeout;
  logic w_if_keep, w_id_keep, w_ex_keep;
  logic w_id_nop, w_ex_nop, w_wb_nop;
  logic w_pc_sel_br, w_err;
  logic w_any_keep;

  assign w_mem_stall = i_mem_req & ~i_mem_ready;

  // x0 is never a real dependency, so a load targeting it cannot interlock
  assign w_lu_hz = i_ex_is_load & i_ex_regwrite & (i_ex_wreg != 5'd0) &
                   ((i_id_use_rs1 & (i_id_rs1 == i_ex_wreg)) |
                    (i_id_use_rs2 & (i_id_rs2 == i_ex_wreg)));

  assign w_timeout = TO_EN && (r_state == S_MEM_WAIT) && w_mem_stall &&
                     (r_wait_cnt == TIMEOUT);

  // Zero-cycle control response; reset forces the bubble pattern
  always_comb begin
    w_if_keep   = 1'b0;
    w_id_keep   = 1'b0;
    w_ex_keep   = 1'b0;
    w_id_nop    = 1'b0;
    w_ex_nop    = 1'b0;
    w_wb_nop    = 1'b0;
    w_pc_sel_br = 1'b0;
    w_err       = 1'b0;
    if (!rst) begin
      w_id_nop = 1'b1;
      w_ex_nop = 1'b1;
      w_wb_nop = 1'b1;
    end else if (r_state == S_ERR) begin
      w_if_keep = 1'b1;
      w_id_keep = 1'b1;
      w_ex_keep = 1'b1;
      w_wb_nop  = 1'b1;
      w_err     = 1'b1;
    end else if (w_mem_stall) begin
      w_if_keep = 1'b1;
      w_id_keep = 1'b1;
      w_ex_keep = 1'b1;
      w_wb_nop  = 1'b1;
      w_err     = w_timeout;
    end else if (i_br_taken) begin
      w_pc_sel_br = 1'b1;
      w_id_nop    = 1'b1;
      w_ex_nop    = 1'b1;
    end else if (w_lu_hz) begin
      w_if_keep = 1'b1;
      w_id_keep = 1'b1;
      w_ex_nop  = 1'b1;
    end
  end

  assign w_any_keep = w_if_keep | w_id_keep | w_ex_keep;

  // State, wait timer and saturating perf counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_RUN;
      r_wait_cnt  <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_any_keep && (r_stall_cnt != CNT_MAX)) r_stall_cnt <= r_stall_cnt + CNT_ONE;
      if (w_pc_sel_br && (r_flush_cnt != CNT_MAX)) r_flush_cnt <= r_flush_cnt + CNT_ONE;
      case (r_state)
        S_RUN: begin
          if (w_mem_stall) begin
            r_state    <= S_MEM_WAIT;
            r_wait_cnt <= CNT_ONE;
          end
        end
        S_MEM_WAIT: begin
          if (!w_mem_stall) begin
            r_state    <= S_RUN;
            r_wait_cnt <= '0;
          end else if (w_timeout) begin
            r_state <= S_ERR;
          end else if (r_wait_cnt != CNT_MAX) begin
            r_wait_cnt <= r_wait_cnt + CNT_ONE;
          end
        end
        S_ERR: begin
          r_state <= S_ERR;
        end
        default: begin
          r_state    <= S_RUN;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

  assign o_if_keep   = w_if_keep;
  assign o_id_keep   = w_id_keep;
  assign o_ex_keep   = w_ex_keep;
  assign o_id_nop    = w_id_nop;
  assign o_ex_nop    = w_ex_nop;
  assign o_wb_nop    = w_wb_nop;
  assign o_pc_sel_br = w_pc_sel_br;
  assign o_err       = w_err;
  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: directed vectors push hand-computed
// expectations; a negedge monitor pops and compares each cycle.
module tb_hazard_stall_ctrl;

  localparam int unsigned MEM_TIMEOUT = 4;
  localparam int unsigned CNT_W       = 3;

  // Control bit order: if_keep id_keep ex_keep id_nop ex_nop wb_nop pc_sel_br err
  localparam logic [7:0] C_RST  = 8'b000_111_0_0;
  localparam logic [7:0] C_NONE = 8'b000_000_0_0;
  localparam logic [7:0] C_LU   = 8'b110_010_0_0;
  localparam logic [7:0] C_BR   = 8'b000_110_1_0;
  localparam logic [7:0] C_MEM  = 8'b111_001_0_0;
  localparam logic [7:0] C_ERR  = 8'b111_001_0_1;

  typedef struct {
    string            name;
    logic [7:0]       ctl;
    logic [CNT_W-1:0] stall;
    logic [CNT_W-1:0] flush;
  } exp_t;

  logic clk, rst;
  logic [4:0] id_rs1, id_rs2, ex_wreg;
  logic id_use_rs1, id_use_rs2, ex_regwrite, ex_is_load, br_taken, mem_req, mem_ready;
  logic if_keep, id_keep, ex_keep, id_nop, ex_nop, wb_nop, pc_sel_br, err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  hazard_stall_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
    .i_id_use_rs1(id_use_rs1), .i_id_use_rs2(id_use_rs2),
    .i_ex_wreg(ex_wreg), .i_ex_regwrite(ex_regwrite), .i_ex_is_load(ex_is_load),
    .i_br_taken(br_taken), .i_mem_req(mem_req), .i_mem_ready(mem_ready),
    .o_if_keep(if_keep), .o_id_keep(id_keep), .o_ex_keep(ex_keep),
    .o_id_nop(id_nop), .o_ex_nop(ex_nop), .o_wb_nop(wb_nop),
    .o_pc_sel_br(pc_sel_br), .o_err(err),
    .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of inputs just after the edge and queue its expectation
  task automatic step(input string name, input logic r,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2,
                      input logic [4:0] wreg, input logic rw, input logic ld,
                      input logic br, input logic req, input logic rdy,
                      input logic [7:0] ctl, input int s, input int f);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    ex_wreg = wreg; ex_regwrite = rw; ex_is_load = ld;
    br_taken = br; mem_req = req; mem_ready = rdy;
    e.name = name; e.ctl = ctl; e.stall = CNT_W'(s); e.flush = CNT_W'(f);
    sb_q.push_back(e);
  endtask

  task automatic idle(input string name, input logic [7:0] ctl, input int s, input int f);
    step(name, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ctl, s, f);
  endtask

  task automatic mem(input string name, input logic r, input logic req, input logic rdy,
                     input logic br, input logic [7:0] ctl, input int s, input int f);
    step(name, r, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, br, req, rdy, ctl, s, f);
  endtask

  // Monitor: every cycle is an output presentation
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      exp_t e;
      logic [7:0] act;
      e = sb_q.pop_front();
      act = {if_keep, id_keep, ex_keep, id_nop, ex_nop, wb_nop, pc_sel_br, err};
      n_cmp++;
      if (act !== e.ctl) begin
        n_bad++;
        $display("FAIL %s ctl: got %b expected %b", e.name, act, e.ctl);
      end
      n_cmp++;
      if (stall_cnt !== e.stall) begin
        n_bad++;
        $display("FAIL %s stall_cnt: got %0d expected %0d", e.name, stall_cnt, e.stall);
      end
      n_cmp++;
      if (flush_cnt !== e.flush) begin
        n_bad++;
        $display("FAIL %s flush_cnt: got %0d expected %0d", e.name, flush_cnt, e.flush);
      end
    end
  end

  initial begin
    rst = 1'b0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_wreg = '0; ex_regwrite = 1'b0; ex_is_load = 1'b0;
    br_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;

    mem("reset", 1'b0, 1'b0, 1'b0, 1'b0, C_RST, 0, 0);
    idle("run_idle", C_NONE, 0, 0);
    step("lu_rs1",   1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, C_LU,   0, 0);
    step("lu_clear", 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, 1, 0);
    step("lu_rs2",   1'b1, 5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, C_LU,   1, 0);
    step("lu_x0",    1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, C_NONE, 2, 0);
    step("lu_nouse", 1'b1, 5'd5, 5'd5, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, C_NONE, 2, 0);
    step("lu_noload",1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, 2, 0);
    step("br_over_lu",1'b1,5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, C_BR,   2, 0);
    idle("after_br", C_NONE, 2, 1);
    mem("mw1", 1'b1, 1'b1, 1'b0, 1'b0, C_MEM, 2, 1);
    mem("mw2", 1'b1, 1'b1, 1'b0, 1'b0, C_MEM, 3, 1);
    mem("mw3", 1'b1, 1'b1, 1'b0, 1'b0, C_MEM, 4, 1);
    mem("mw_ready", 1'b1, 1'b1, 1'b1, 1'b0, C_NONE, 5, 1);
    mem("mem_over_br", 1'b1, 1'b1, 1'b0, 1'b1, C_MEM, 5, 1);
    mem("req_drop_br", 1'b1, 1'b0, 1'b0, 1'b1, C_BR, 6, 1);
    idle("back_run", C_NONE, 6, 2);
    mem("to1", 1'b1, 1'b1, 1'b0, 1'b0, C_MEM, 6, 2);
    mem("to2_sat", 1'b1, 1'b1, 1'b0, 1'b0, C_MEM, 7, 2);
    mem("to3", 1'b1, 1'b1, 1'b0, 1'b0, C_MEM, 7, 2);
    mem("to4", 1'b1, 1'b1, 1'b0, 1'b0, C_MEM, 7, 2);
    mem("to5_err", 1'b1, 1'b1, 1'b0, 1'b0, C_ERR, 7, 2);
    mem("err_sticky_br", 1'b1, 1'b0, 1'b0, 1'b1, C_ERR, 7, 2);
    mem("err_sticky_rdy", 1'b1, 1'b1, 1'b1, 1'b0, C_ERR, 7, 2);
    mem("err_reset", 1'b0, 1'b0, 1'b0, 1'b0, C_RST, 0, 0);
    idle("post_err_run", C_NONE, 0, 0);
    for (int i = 0; i < 9; i++)
      mem($sformatf("flush_%0d", i), 1'b1, 1'b0, 1'b0, 1'b1, C_BR, 0, (i < 7) ? i : 7);
    idle("flush_sat", C_NONE, 0, 7);
    mem("rw1", 1'b1, 1'b1, 1'b0, 1'b0, C_MEM, 0, 7);
    mem("rw2", 1'b1, 1'b1, 1'b0, 1'b0, C_MEM, 1, 7);
    mem("rst_in_wait", 1'b0, 1'b1, 1'b0, 1'b0, C_RST, 0, 0);
    mem("run_after_rst", 1'b1, 1'b1, 1'b0, 1'b0, C_MEM, 0, 0);
    mem("ready_after_rst", 1'b1, 1'b1, 1'b1, 1'b0, C_NONE, 1, 0);
    idle("final_idle", C_NONE, 1, 0);

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
